i2s_tx_serializer: RTL and testbench

I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

---
 rtl/i2s_tx_serializer_if.sv | 9 +
 rtl/i2s_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_serializer_if.sv
// rtl/i2s_tx_serializer_if.sv - PCM word handshake between a sample source and the I2S serializer
interface i2s_tx_serializer_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S / MSB- / LSB-justified transmit serializer driven by sck falling-edge strobes
module i2s_tx_serializer (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_sck_fe,
    input  logic [1:0]                 i_standard,
    input  logic [1:0]                 i_word_size,
    input  logic                       i_frame_size,
    input  logic                       i_stereo,
    input  logic                       i_mute,
    input  logic                       i_stop,
    i2s_tx_serializer_if.slave         s_tx,
    output logic                       o_sd,
    output logic                       o_ws,
    output logic                       o_idle,
    output logic                       o_underrun,
    output logic                       o_err
);
    typedef enum logic [1:0] {S_IDLE, S_L, S_R, S_ERR} state_t;

    state_t      r_state, w_n_state;
    logic [4:0]  r_cnt, w_n_cnt;
    logic [31:0] r_word, w_n_word, w_word_in;
    logic [1:0]  r_std, r_wsz;
    logic        r_fsz, r_stereo;
    logic        r_prev_bit;
    logic        r_sd;

    logic [1:0]  w_std, w_wsz;
    logic        w_fsz;
    logic [4:0]  w_f_last, w_e_last, w_off, w_idx;
    logic        w_e_eq_f, w_fetch, w_enter, w_bit_ok, w_sd_next;

    // In IDLE the live config is used so the first slot is computed with what gets latched.
    assign w_std    = (r_state == S_IDLE) ? i_standard   : r_std;
    assign w_wsz    = (r_state == S_IDLE) ? i_word_size  : r_wsz;
    assign w_fsz    = (r_state == S_IDLE) ? i_frame_size : r_fsz;
    assign w_f_last = w_fsz ? 5'd31 : 5'd15;
    assign w_e_eq_f = !w_fsz || w_wsz[1];
    assign w_off    = w_f_last - w_e_last;

    always_comb begin
        w_e_last = 5'd31;
        if (!w_fsz)               w_e_last = 5'd15;
        else if (w_wsz == 2'b00)  w_e_last = 5'd15;
        else if (w_wsz == 2'b01)  w_e_last = 5'd23;
    end

    always_comb begin
        w_n_state = r_state;
        w_n_cnt   = r_cnt;
        w_fetch   = 1'b0;
        w_enter   = 1'b0;
        if (i_sck_fe) begin
            case (r_state)
                S_IDLE: if (!i_stop) begin
                    if (i_standard == 2'b11) begin
                        w_n_state = S_ERR;
                    end else begin
                        w_n_state = S_L;
                        w_n_cnt   = 5'd0;
                        w_fetch   = 1'b1;
                        w_enter   = 1'b1;
                    end
                end
                S_L: if (r_cnt == w_f_last) begin
                    w_n_state = S_R;
                    w_n_cnt   = 5'd0;
                    w_enter   = 1'b1;
                    w_fetch   = r_stereo;
                end else begin
                    w_n_cnt = r_cnt + 5'd1;
                end
                S_R: if (r_cnt == w_f_last) begin
                    w_n_cnt = 5'd0;
                    if (i_stop) begin
                        w_n_state = S_IDLE;
                    end else begin
                        w_n_state = S_L;
                        w_fetch   = 1'b1;
                        w_enter   = 1'b1;
                    end
                end else begin
                    w_n_cnt = r_cnt + 5'd1;
                end
                default: if (i_stop) w_n_state = S_IDLE;
            endcase
        end
    end

    assign w_word_in = s_tx.tx_valid ? s_tx.tx_data : 32'd0;
    assign w_n_word  = w_fetch ? w_word_in : r_word;

    // Bit for the slot being entered, taken from the word that will be current after this strobe.
    always_comb begin
        w_sd_next = 1'b0;
        w_bit_ok  = 1'b0;
        w_idx     = 5'd0;
        if ((w_n_state == S_L || w_n_state == S_R) && !i_mute) begin
            case (w_std)
                2'b01: begin
                    w_bit_ok = (w_n_cnt <= w_e_last);
                    w_idx    = w_e_last - w_n_cnt;
                end
                2'b10: begin
                    w_bit_ok = (w_n_cnt >= w_off);
                    w_idx    = w_e_last - (w_n_cnt - w_off);
                end
                2'b00: begin
                    if (w_n_cnt == 5'd0) begin
                        w_sd_next = r_prev_bit;
                    end else begin
                        w_bit_ok = ((w_n_cnt - 5'd1) <= w_e_last);
                        w_idx    = w_e_last - (w_n_cnt - 5'd1);
                    end
                end
                default: w_bit_ok = 1'b0;
            endcase
            if (w_bit_ok) w_sd_next = w_n_word[w_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_word     <= 32'd0;
            r_std      <= 2'b00;
            r_wsz      <= 2'b00;
            r_fsz      <= 1'b0;
            r_stereo   <= 1'b0;
            r_prev_bit <= 1'b0;
            r_sd       <= 1'b0;
        end else if (i_sck_fe) begin
            r_state <= w_n_state;
            r_cnt   <= w_n_cnt;
            r_word  <= w_n_word;
            r_sd    <= w_sd_next;
            if (r_state == S_IDLE && !i_stop) begin
                r_std    <= i_standard;
                r_wsz    <= i_word_size;
                r_fsz    <= i_frame_size;
                r_stereo <= i_stereo;
            end
            // Holds the slot-F bit of the channel now starting; I2S shifts it into the next slot 0.
            if (w_n_state == S_IDLE)
                r_prev_bit <= 1'b0;
            else if (w_enter)
                r_prev_bit <= w_e_eq_f & w_n_word[0];
        end
    end

    assign s_tx.tx_ready = w_fetch & rst_n;
    assign o_underrun    = w_fetch & rst_n & !s_tx.tx_valid;
    assign o_sd          = r_sd;
    assign o_ws          = (r_state == S_R);
    assign o_idle        = (r_state == S_IDLE);
    assign o_err         = (r_state == S_ERR);
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - directed table and sequence bench for i2s_tx_serializer
module tb_i2s_tx_serializer;
    logic       clk = 1'b0;
    logic       rst_n, sck_fe, frame_size, stereo, mute, stop;
    logic [1:0] standard, word_size;
    logic       sd, ws, idle, underrun, err;

    i2s_tx_serializer_if txi ();

    i2s_tx_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sck_fe     (sck_fe),
        .i_standard   (standard),
        .i_word_size  (word_size),
        .i_frame_size (frame_size),
        .i_stereo     (stereo),
        .i_mute       (mute),
        .i_stop       (stop),
        .s_tx         (txi.slave),
        .o_sd         (sd),
        .o_ws         (ws),
        .o_idle       (idle),
        .o_underrun   (underrun),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  std;
        logic [1:0]  wsz;
        logic        fsz;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [10];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic strobe(output logic rdy, output logic und);
        @(negedge clk);
        sck_fe = 1'b1;
        #1;
        rdy = txi.tx_ready;
        und = underrun;
        @(negedge clk);
        sck_fe = 1'b0;
        #1;
    endtask

    task automatic run_chan(input int f, output logic [31:0] pat, output logic [31:0] wsp,
                            output int nrdy, output int nund);
        logic r, u;
        pat = 0; wsp = 0; nrdy = 0; nund = 0;
        for (int k = 0; k < f; k++) begin
            strobe(r, u);
            pat  = {pat[30:0], sd};
            wsp  = {wsp[30:0], ws};
            nrdy += int'(r);
            nund += int'(u);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sck_fe = 1'b0; stop = 1'b0; mute = 1'b0; stereo = 1'b1;
        txi.tx_valid = 1'b0; txi.tx_data = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic cfg(input logic [1:0] s, input logic [1:0] w, input logic f);
        standard = s; word_size = w; frame_size = f;
    endtask

    initial begin
        logic [31:0] pat, wsp;
        int          nrdy, nund, f, sd_or;
        logic        r, u;

        vt[0] = '{2'b01, 2'b00, 1'b0, 32'h0000A5A5, 32'h0000A5A5};
        vt[1] = '{2'b00, 2'b01, 1'b1, 32'h00C00001, 32'h60000080};
        vt[2] = '{2'b10, 2'b00, 1'b1, 32'h00008001, 32'h00008001};
        vt[3] = '{2'b01, 2'b10, 1'b0, 32'hFFFF1234, 32'h00001234};
        vt[4] = '{2'b01, 2'b01, 1'b1, 32'h00ABCDEF, 32'hABCDEF00};
        vt[5] = '{2'b00, 2'b00, 1'b0, 32'h00008001, 32'h00004000};
        vt[6] = '{2'b10, 2'b10, 1'b0, 32'hDEAD0F0F, 32'h00000F0F};
        vt[7] = '{2'b10, 2'b01, 1'b1, 32'h00123456, 32'h00123456};
        vt[8] = '{2'b01, 2'b00, 1'b1, 32'hFFFFBEEF, 32'hBEEF0000};
        vt[9] = '{2'b01, 2'b11, 1'b1, 32'h87654321, 32'h87654321};

        cfg(2'b01, 2'b00, 1'b0);
        do_reset();
        chk("reset_outputs", {26'd0, sd, ws, idle, err, txi.tx_ready, underrun}, 32'b001000);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            cfg(vt[i].std, vt[i].wsz, vt[i].fsz);
            txi.tx_data = vt[i].word; txi.tx_valid = 1'b1;
            f = vt[i].fsz ? 32 : 16;
            run_chan(f, pat, wsp, nrdy, nund);
            chk($sformatf("vec%0d_sd", i), pat, vt[i].exp);
            chk($sformatf("vec%0d_ws", i), wsp, 32'd0);
            chk($sformatf("vec%0d_rdy", i), nrdy, 1);
        end

        // Stereo MSB frame, two words
        do_reset();
        cfg(2'b01, 2'b00, 1'b0);
        txi.tx_data = 32'h0000A5A5; txi.tx_valid = 1'b1;
        run_chan(16, pat, wsp, nrdy, nund);
        chk("msb_l_sd", pat, 32'hA5A5);
        txi.tx_data = 32'h000000FF;
        run_chan(16, pat, wsp, nrdy, nund);
        chk("msb_r_sd", pat, 32'h00FF);
        chk("msb_r_ws", wsp, 32'hFFFF);
        chk("msb_r_rdy", nrdy, 1);

        // I2S E==F: L LSB carried into R slot 0
        do_reset();
        cfg(2'b00, 2'b00, 1'b0);
        txi.tx_data = 32'h00008001; txi.tx_valid = 1'b1;
        run_chan(16, pat, wsp, nrdy, nund);
        txi.tx_data = 32'h0;
        run_chan(16, pat, wsp, nrdy, nund);
        chk("i2s_carry_r_sd", pat, 32'h8000);

        // Trim + underrun on R, stop raised together with R fetch
        do_reset();
        cfg(2'b01, 2'b10, 1'b0);
        txi.tx_data = 32'hFFFF1234; txi.tx_valid = 1'b1;
        run_chan(16, pat, wsp, nrdy, nund);
        chk("trim_l_sd", pat, 32'h1234);
        chk("trim_l_und", nund, 0);
        txi.tx_valid = 1'b0; txi.tx_data = 32'hFFFFFFFF; stop = 1'b1;
        run_chan(16, pat, wsp, nrdy, nund);
        chk("und_r_sd", pat, 32'h0);
        chk("und_r_count", nund, 1);
        chk("und_r_rdy", nrdy, 1);
        strobe(r, u);
        chk("stop_idle", {30'd0, idle, ws}, 32'b10);
        chk("stop_no_rdy", r, 1'b0);

        // Mono + mute, stop during L slot 5
        do_reset();
        cfg(2'b01, 2'b00, 1'b0);
        stereo = 1'b0; mute = 1'b1;
        txi.tx_data = 32'h0000FFFF; txi.tx_valid = 1'b1;
        sd_or = 0; nrdy = 0;
        for (int k = 0; k < 32; k++) begin
            strobe(r, u);
            sd_or |= int'(sd);
            nrdy  += int'(r);
            if (k == 5) stop = 1'b1;
        end
        chk("mono_mute_sd", sd_or, 0);
        chk("mono_mute_rdy", nrdy, 1);
        chk("mono_last_slot", {30'd0, idle, ws}, 32'b01);
        strobe(r, u);
        chk("mono_stop_idle", {30'd0, idle, ws}, 32'b10);

        // Mono without mute: R repeats the L word, new tx_data ignored
        do_reset();
        cfg(2'b01, 2'b00, 1'b0);
        stereo = 1'b0;
        txi.tx_data = 32'h00001234; txi.tx_valid = 1'b1;
        run_chan(16, pat, wsp, nrdy, nund);
        txi.tx_data = 32'h0000FFFF;
        run_chan(16, pat, wsp, nrdy, nund);
        chk("mono_r_sd", pat, 32'h1234);
        chk("mono_r_rdy", nrdy, 0);

        // Reserved standard -> ERR, exit with stop
        do_reset();
        cfg(2'b11, 2'b00, 1'b0);
        txi.tx_valid = 1'b1;
        strobe(r, u);
        chk("err_rdy", r, 1'b0);
        chk("err_state", {30'd0, err, idle}, 32'b10);
        strobe(r, u);
        chk("err_hold", err, 1'b1);
        stop = 1'b1;
        strobe(r, u);
        chk("err_exit", {30'd0, err, idle}, 32'b01);

        // Reset mid-R
        do_reset();
        cfg(2'b01, 2'b00, 1'b0);
        txi.tx_data = 32'h0000FFFF; txi.tx_valid = 1'b1;
        run_chan(16, pat, wsp, nrdy, nund);
        run_chan(3, pat, wsp, nrdy, nund);
        chk("pre_reset", {30'd0, sd, ws}, 32'b11);
        @(negedge clk);
        #2;
        sck_fe = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("async_reset", {26'd0, sd, ws, idle, err, txi.tx_ready, underrun}, 32'b001000);
        @(negedge clk);
        sck_fe = 1'b0;
        rst_n  = 1'b1;
        stop   = 1'b1;
        #1;
        strobe(r, u);
        chk("post_reset_hold", {30'd0, idle, r}, 32'b10);
        stop = 1'b0;
        strobe(r, u);
        chk("post_reset_resume", {30'd0, idle, r}, 32'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
